// File: rtl/data_ram_timer.sv
// rtl/data_ram_timer.sv - data-memory responder: byte-lane word RAM plus memory-mapped timer
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   ce_i[3:0]     access enable (any bit set = access)
//   we_i          1 = write, 0 = read
//   addr_i[31:0]  byte address; bit 31 selects timer (1) or RAM (0)
//   sel_i[3:0]    byte-lane enables, sel_i[k] covers data bits [8k+7:8k]
//   data_i[31:0]  write data
//   data_o[31:0]  combinational read data (0 when not reading or in reset)
//   irq_o         timer interrupt, STATUS.MATCH & CTRL.IE
module data_ram_timer #(
   parameter int          ADDR_W      = 10,
   parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        irq_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem [DEPTH];

   logic [31:0] count_q,   count_d;
   logic [31:0] compare_q, compare_d;
   logic        match_q,   match_d;
   logic [1:0]  ctrl_q,    ctrl_d;

   logic              acc_en;
   logic              wr_en;
   logic              rd_en;
   logic              tmr_sel;
   logic [1:0]        reg_idx;
   logic [ADDR_W-1:0] word_idx;
   logic              ram_we;
   logic              match_set;
   logic              match_clr;

   // Address bits that play no part in decoding.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[30:ADDR_W+2], addr_i[1:0]};

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      for (int k = 0; k < 4; k++) begin
         res[8*k +: 8] = sel[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
      end
      return res;
   endfunction

   assign acc_en   = (ce_i != 4'b0000);
   assign wr_en    = acc_en & we_i;
   assign rd_en    = acc_en & ~we_i;
   assign tmr_sel  = addr_i[31];
   assign reg_idx  = addr_i[3:2];
   assign word_idx = addr_i[ADDR_W+1:2];

   // rst gates the RAM write so a write presented during reset is dropped.
   assign ram_we = wr_en & ~tmr_sel & ~rst;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[word_idx] <= lane_merge(mem[word_idx], data_i, sel_i);
      end
   end

   always_comb begin
      count_d   = count_q;
      compare_d = compare_q;
      ctrl_d    = ctrl_q;

      // Match compares the pre-edge COUNT/COMPARE, so a same-edge COMPARE write is not seen.
      match_set = ctrl_q[0] & (count_q == compare_q);
      match_clr = wr_en & tmr_sel & (reg_idx == 2'd2) & sel_i[0] & data_i[0];
      // Set wins over a simultaneous write-1-to-clear.
      match_d   = match_set | (match_q & ~match_clr);

      if (wr_en && tmr_sel && reg_idx == 2'd0) begin
         // A COUNT write replaces the increment on this edge.
         count_d = lane_merge(count_q, data_i, sel_i);
      end else if (ctrl_q[0]) begin
         count_d = count_q + 32'd1;
      end

      if (wr_en && tmr_sel && reg_idx == 2'd1) begin
         compare_d = lane_merge(compare_q, data_i, sel_i);
      end

      if (wr_en && tmr_sel && reg_idx == 2'd3 && sel_i[0]) begin
         ctrl_d = data_i[1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= 32'd0;
         compare_q <= COMPARE_RST;
         match_q   <= 1'b0;
         ctrl_q    <= 2'b00;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         match_q   <= match_d;
         ctrl_q    <= ctrl_d;
      end
   end

   always_comb begin
      data_o = 32'd0;
      if (!rst && rd_en) begin
         if (tmr_sel) begin
            case (reg_idx)
               2'd0:    data_o = count_q;
               2'd1:    data_o = compare_q;
               2'd2:    data_o = {31'd0, match_q};
               default: data_o = {30'd0, ctrl_q};
            endcase
         end else begin
            data_o = mem[word_idx];
         end
      end
   end

   assign irq_o = match_q & ctrl_q[1];

endmodule
